// File: rtl/sound_pkg.sv
// Shared definitions for the sound chip timing blocks: frame step masks,
// field widths and the frame-step decode helper.
package sound_pkg;

    localparam int SEQ_STEPS = 8;
    localparam int SEQ_W     = 3;
    localparam int PERIOD_W  = 3;

    // Bit n of each mask selects whether frame step n fires that tick.
    localparam logic [SEQ_STEPS-1:0] LEN_STEP_MASK   = 8'b0101_0101;
    localparam logic [SEQ_STEPS-1:0] SWEEP_STEP_MASK = 8'b0100_0100;
    localparam logic [SEQ_STEPS-1:0] ENV_STEP_MASK   = 8'b1000_0000;

    typedef struct packed {
        logic length;
        logic sweep;
        logic env;
    } frame_ticks_t;

    function automatic frame_ticks_t decode_step(input logic [SEQ_W-1:0] seq);
        frame_ticks_t t;
        t.length = LEN_STEP_MASK[seq];
        t.sweep  = SWEEP_STEP_MASK[seq];
        t.env    = ENV_STEP_MASK[seq];
        return t;
    endfunction

endpackage

// File: rtl/env_divider.sv
// Per-channel envelope period divider: counts envelope frames and emits a
// one-cycle step pulse each time the programmed period elapses.
module env_divider
    import sound_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                trigger,
    input  logic                frame,
    input  logic [PERIOD_W-1:0] period,
    output logic                step_pulse
);

    logic [PERIOD_W-1:0] count_q, count_d;
    logic                step_pulse_q, step_pulse_d;

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        count_d      = count_q;
        step_pulse_d = 1'b0;
        if (!enable) begin
            count_d = '0;
        end else if (trigger) begin
            // A trigger reloads and swallows any envelope frame on the same edge.
            count_d = period;
        end else if (frame && period != '0) begin
            if (count_q <= PERIOD_W'(1)) begin
                step_pulse_d = 1'b1;
                count_d      = period;
            end else begin
                count_d = count_q - PERIOD_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q      <= '0;
            step_pulse_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            step_pulse_q <= step_pulse_d;
        end
    end

    assign step_pulse = step_pulse_q;

endmodule

// File: rtl/frame_sequencer.sv
// Sound chip frame sequencer: divides the system clock to the frame rate,
// walks the 8-step sequence and issues length/sweep/envelope clock enables.
module frame_sequencer
    import sound_pkg::*;
#(
    parameter int DIV    = 8192,
    parameter int NUM_CH = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [NUM_CH-1:0]            trigger,
    input  logic [PERIOD_W*NUM_CH-1:0]   env_period,
    output logic [SEQ_W-1:0]             step,
    output logic                         length_tick,
    output logic                         sweep_tick,
    output logic                         env_tick,
    output logic [NUM_CH-1:0]            env_step
);

    localparam int PRE_W = $clog2(DIV);

    logic [PRE_W-1:0] prescaler_q, prescaler_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic [SEQ_W-1:0] step_q, step_d;
    frame_ticks_t     ticks_q, ticks_d;
    logic             frame_edge;
    logic             env_frame;
    logic [NUM_CH-1:0] env_step_raw;

    assign frame_edge = enable && (prescaler_q == PRE_W'(DIV - 1));

    always_comb begin
        prescaler_d = prescaler_q + PRE_W'(1);
        seq_d       = seq_q;
        step_d      = step_q;
        ticks_d     = '0;
        if (!enable) begin
            prescaler_d = '0;
            seq_d       = '0;
            step_d      = '0;
        end else if (frame_edge) begin
            // Ticks and the reported step come from the pre-increment sequence value.
            prescaler_d = '0;
            seq_d       = seq_q + SEQ_W'(1);
            step_d      = seq_q;
            ticks_d     = decode_step(seq_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler_q <= '0;
            seq_q       <= '0;
            step_q      <= '0;
            ticks_q     <= '0;
        end else begin
            prescaler_q <= prescaler_d;
            seq_q       <= seq_d;
            step_q      <= step_d;
            ticks_q     <= ticks_d;
        end
    end

    // Dividers see the envelope frame on the same edge env_tick registers high.
    assign env_frame = ticks_d.env;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_env_div
        env_divider u_env_divider (
            .clk        (clk),
            .rst        (rst),
            .enable     (enable),
            .trigger    (trigger[ch]),
            .frame      (env_frame),
            .period     (env_period[PERIOD_W*ch +: PERIOD_W]),
            .step_pulse (env_step_raw[ch])
        );
    end

    // Gating keeps every output quiet as soon as enable drops, not one edge later.
    assign step        = enable ? step_q : '0;
    assign length_tick = enable & ticks_q.length;
    assign sweep_tick  = enable & ticks_q.sweep;
    assign env_tick    = enable & ticks_q.env;
    assign env_step    = env_step_raw & {NUM_CH{enable}};

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench for frame_sequencer: directed frame/envelope scenarios
// followed by randomized stimulus against a cycle-count based reference model.
module tb_frame_sequencer;

    localparam int DIV    = 4;
    localparam int NUM_CH = 3;
    localparam int FRAME8 = 8 * DIV;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 enable;
    logic [NUM_CH-1:0]    trigger;
    logic [3*NUM_CH-1:0]  env_period;
    logic [2:0]           step;
    logic                 length_tick;
    logic                 sweep_tick;
    logic                 env_tick;
    logic [NUM_CH-1:0]    env_step;

    always #5 clk = ~clk;

    frame_sequencer #(
        .DIV    (DIV),
        .NUM_CH (NUM_CH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .trigger     (trigger),
        .env_period  (env_period),
        .step        (step),
        .length_tick (length_tick),
        .sweep_tick  (sweep_tick),
        .env_tick    (env_tick),
        .env_step    (env_step)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Reference model: time is counted in enabled cycles since (re)start;
    // frame k fires after (k+1)*DIV cycles and executes step k mod 8.
    int          m_t;
    int          m_cnt [NUM_CH];
    int          e_step;
    bit          e_len, e_sweep, e_env;
    bit [NUM_CH-1:0] e_es;

    task automatic model_reset();
        m_t = 0;
        e_step = 0;
        e_len = 0; e_sweep = 0; e_env = 0; e_es = '0;
        for (int ch = 0; ch < NUM_CH; ch++) m_cnt[ch] = 0;
    endtask

    task automatic model_edge();
        int s;
        int per;
        e_len = 0; e_sweep = 0; e_env = 0; e_es = '0;
        if (!enable) begin
            model_reset();
        end else begin
            m_t++;
            if (m_t % DIV == 0) begin
                s       = (m_t / DIV - 1) % 8;
                e_step  = s;
                e_len   = (s % 2 == 0);
                e_sweep = (s % 4 == 2);
                e_env   = (s == 7);
            end
            for (int ch = 0; ch < NUM_CH; ch++) begin
                per = int'(env_period[3*ch +: 3]);
                if (trigger[ch]) begin
                    m_cnt[ch] = per;
                end else if (e_env && per != 0) begin
                    if (m_cnt[ch] <= 1) begin
                        e_es[ch]  = 1'b1;
                        m_cnt[ch] = per;
                    end else begin
                        m_cnt[ch] = m_cnt[ch] - 1;
                    end
                end
            end
        end
    endtask

    logic                cur_en;
    logic [3*NUM_CH-1:0] cur_per;

    // One clock: drive at negedge, step the model at posedge, compare 1 unit later.
    task automatic tick(input logic [NUM_CH-1:0] trig);
        @(negedge clk);
        enable     = cur_en;
        trigger    = trig;
        env_period = cur_per;
        @(posedge clk);
        model_edge();
        #1;
        check("model_step",        step,        e_step);
        check("model_length_tick", length_tick, e_len);
        check("model_sweep_tick",  sweep_tick,  e_sweep);
        check("model_env_tick",    env_tick,    e_env);
        check("model_env_step",    env_step,    e_es);
    endtask

    task automatic wait_env(input string tag);
        bit found = 0;
        for (int i = 0; i < FRAME8 + 8 && !found; i++) begin
            tick('0);
            if (env_tick === 1'b1) found = 1;
        end
        if (!found) check({tag, "_env_timeout"}, 0, 1);
    endtask

    function automatic logic [31:0] all_outputs();
        return {23'd0, step, length_tick, sweep_tick, env_tick, env_step};
    endfunction

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        rst        = 1'b1;
        enable     = 1'b0;
        trigger    = '0;
        env_period = '0;
        cur_en     = 1'b0;
        cur_per    = '0;
        model_reset();

        @(negedge clk);
        @(negedge clk);
        check("reset_outputs", all_outputs(), 0);
        rst = 1'b0;

        // Basic frame sequence after reset.
        cur_en = 1'b1;
        for (int c = 1; c <= 32; c++) begin
            tick('0);
            check("s1_length_tick", length_tick, (c % 8 == 4));
            check("s1_sweep_tick",  sweep_tick,  (c == 12 || c == 28));
            check("s1_env_tick",    env_tick,    (c == 32));
            if (c % 4 == 0) check("s1_step", step, c / 4 - 1);
        end

        // Periods ch0=1, ch1=2, ch2=0; trigger all; three envelope frames.
        cur_per = {3'd0, 3'd2, 3'd1};
        tick(3'b111);
        for (int f = 1; f <= 3; f++) begin
            wait_env("s2");
            check("s2_env_step", env_step, (f == 2) ? 3'b011 : 3'b001);
        end

        // Trigger ch0 on the very edge of an envelope frame.
        found = 0;
        for (int i = 0; i < FRAME8 + 4 && !found; i++) begin
            if ((m_t + 1) % FRAME8 == 0) found = 1;
            else tick('0);
        end
        tick(3'b001);
        check("s3_env_tick_same_edge", env_tick, 1);
        check("s3_es0_suppressed", env_step[0], 0);
        wait_env("s3");
        check("s3_es0_next_frame", env_step[0], 1);

        // ch1 period 3 -> count 2, then reprogram to 7 mid-run.
        cur_per[5:3] = 3'd3;
        tick(3'b010);
        wait_env("s4a");
        check("s4_es1_count3to2", env_step[1], 0);
        cur_per[5:3] = 3'd7;
        wait_env("s4b");
        check("s4_es1_count2to1", env_step[1], 0);
        wait_env("s4c");
        check("s4_es1_expire", env_step[1], 1);
        for (int f = 1; f <= 7; f++) begin
            wait_env("s4d");
            check("s4_es1_period7", env_step[1], (f == 7));
        end

        // Drop enable mid-frame at step 5.
        found = 0;
        for (int i = 0; i < FRAME8 + 8 && !found; i++) begin
            tick('0);
            if (step === 3'd5) found = 1;
        end
        if (!found) check("s5_step5_timeout", 0, 1);
        tick('0);
        cur_en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick(3'b111);
            check("s5_idle_outputs", all_outputs(), 0);
        end
        cur_en = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick('0);
            check("s5_restart_length", length_tick, (c == 4));
        end
        check("s5_restart_step", step, 0);

        // Asynchronous reset while env_tick is high.
        wait_env("s6");
        check("s6_env_tick_high", env_tick, 1);
        #2 rst = 1'b1;
        #1 check("s6_async_clear", all_outputs(), 0);
        model_reset();
        rst = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tick('0);
            check("s6_restart_length", length_tick, (c == 4));
        end
        check("s6_restart_step", step, 0);

        // Randomized traffic checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [NUM_CH-1:0] trig;
            for (int ch = 0; ch < NUM_CH; ch++) trig[ch] = ($urandom_range(15) == 0);
            if ($urandom_range(63) == 0) cur_per = (3*NUM_CH)'($urandom);
            if (cur_en) begin
                if ($urandom_range(399) == 0) cur_en = 1'b0;
            end else if ($urandom_range(3) == 0) begin
                cur_en = 1'b1;
            end
            tick(trig);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
